// File: rtl/xadac_scoreboard.sv
// xadac_scoreboard -- per-ID scoreboard tracking outstanding instructions and pending register writes
// Revision 1.0
`default_nettype none

module xadac_scoreboard #(
  parameter int IdWidth      = 4,
  parameter int Depth        = 16,
  parameter int NoRs         = 2,
  parameter int NoVs         = 3,
  parameter int RegAddrWidth = 5,
  parameter int VecAddrWidth = 5
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  logic                             disp_valid_i,
  output logic                             disp_ready_o,
  input  logic [IdWidth-1:0]               disp_id_i,
  input  logic [RegAddrWidth-1:0]          disp_rd_addr_i,
  input  logic                             disp_rd_clobber_i,
  input  logic [VecAddrWidth-1:0]          disp_vd_addr_i,
  input  logic                             disp_vd_clobber_i,
  input  logic [NoRs*RegAddrWidth-1:0]     disp_rs_addr_i,
  input  logic [NoRs-1:0]                  disp_rs_read_i,
  input  logic [NoVs*VecAddrWidth-1:0]     disp_vs_addr_i,
  input  logic [NoVs-1:0]                  disp_vs_read_i,
  input  logic                             ret_valid_i,
  input  logic [IdWidth-1:0]               ret_id_i,
  output logic                             ret_err_o,
  output logic [$clog2(Depth+1)-1:0]       count_o,
  output logic                             busy_o,
  output logic [2**RegAddrWidth-1:0]       reg_pending_o,
  output logic [2**VecAddrWidth-1:0]       vec_pending_o
);

  localparam int NoSlots  = 2**IdWidth;
  localparam int CntWidth = $clog2(Depth+1);
  localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);

  logic [NoSlots-1:0]      slot_valid;
  logic [NoSlots-1:0]      rd_valid;
  logic [NoSlots-1:0]      vd_valid;
  logic [RegAddrWidth-1:0] rd_addr [NoSlots];
  logic [VecAddrWidth-1:0] vd_addr [NoSlots];
  logic [CntWidth-1:0]     count;
  logic                    ret_err;

  logic raw_hazard;
  logic waw_hazard;
  logic disp_fire;
  logic ret_hit;

  always_comb begin
    reg_pending_o = '0;
    vec_pending_o = '0;
    for (int s = 0; s < NoSlots; s++) begin
      if (slot_valid[s] && rd_valid[s]) reg_pending_o[rd_addr[s]] = 1'b1;
      if (slot_valid[s] && vd_valid[s]) vec_pending_o[vd_addr[s]] = 1'b1;
    end
  end

  // Hazards are judged against registered state only; a same-cycle retire never unblocks dispatch.
  always_comb begin
    raw_hazard = 1'b0;
    for (int i = 0; i < NoRs; i++) begin
      if (disp_rs_read_i[i] && reg_pending_o[disp_rs_addr_i[i*RegAddrWidth +: RegAddrWidth]])
        raw_hazard = 1'b1;
    end
    for (int i = 0; i < NoVs; i++) begin
      if (disp_vs_read_i[i] && vec_pending_o[disp_vs_addr_i[i*VecAddrWidth +: VecAddrWidth]])
        raw_hazard = 1'b1;
    end
    waw_hazard = (disp_rd_clobber_i && (disp_rd_addr_i != '0) && reg_pending_o[disp_rd_addr_i]) ||
                 (disp_vd_clobber_i && vec_pending_o[disp_vd_addr_i]);
  end

  assign disp_ready_o = (count < DepthCnt) && !slot_valid[disp_id_i] &&
                        !raw_hazard && !waw_hazard && !flush_i;
  assign disp_fire    = disp_valid_i && disp_ready_o;
  assign ret_hit      = ret_valid_i && slot_valid[ret_id_i];

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      slot_valid <= '0;
      rd_valid   <= '0;
      vd_valid   <= '0;
      count      <= '0;
      ret_err    <= 1'b0;
    end else begin
      ret_err <= ret_valid_i && !slot_valid[ret_id_i];
      if (ret_hit) slot_valid[ret_id_i] <= 1'b0;
      // A firing dispatch always targets a free slot, so it can never collide with ret_id_i.
      if (disp_fire) begin
        slot_valid[disp_id_i] <= 1'b1;
        rd_valid[disp_id_i]   <= disp_rd_clobber_i && (disp_rd_addr_i != '0);
        vd_valid[disp_id_i]   <= disp_vd_clobber_i;
      end
      case ({disp_fire, ret_hit})
        2'b10:   count <= count + CntWidth'(1);
        2'b01:   count <= count - CntWidth'(1);
        default: count <= count;
      endcase
    end
  end

  // Address fields carry no meaning until their slot is valid, so they skip reset.
  always_ff @(posedge clk_i) begin
    if (disp_fire) begin
      rd_addr[disp_id_i] <= disp_rd_addr_i;
      vd_addr[disp_id_i] <= disp_vd_addr_i;
    end
  end

  assign ret_err_o = ret_err;
  assign count_o   = count;
  assign busy_o    = (count != '0);

endmodule

`default_nettype wire
